// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop (also when full) and flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves this cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, issues credited imem requests,
// queues returned instructions and handles branch redirects.
module if_fetch_unit #(
  parameter int              XLEN     = if_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  import if_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_head;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   occ;
  logic [CW:0]     credit_sum;
  logic            pc_full;
  logic            pc_empty;
  logic            q_full;
  logic            q_empty;
  logic            accept;
  logic            resp;
  logic            drop;
  fetch_entry_t    q_in;
  fetch_entry_t    q_head;
  logic            unused_ok;

  assign credit_sum = {1'b0, occ} + {1'b0, outstanding};

  assign imem_req_valid = !rst && !redirect_valid &&
                          (credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses with nothing in flight are reset stragglers
  assign resp = imem_resp_valid && !pc_empty;
  assign drop = resp && (redirect_valid || discard != '0);

  assign q_in.pc    = pc_head;
  assign q_in.instr = imem_resp_data;

  assign out_valid = !q_empty && !redirect_valid;
  assign out_instr = out_valid ? q_head.instr : NOP_INSTR;
  assign out_pc    = out_valid ? q_head.pc : '0;
  assign occupancy = occ;

  assign unused_ok = &{1'b0, pc_full, q_full};

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (resp),
    .flush (1'b0),
    .din   (fetch_pc),
    .dout  (pc_head),
    .count (outstanding),
    .full  (pc_full),
    .empty (pc_empty)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (resp && !drop),
    .pop   (out_valid && !stall),
    .flush (redirect_valid),
    .din   (q_in),
    .dout  (q_head),
    .count (occ),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      discard  <= outstanding - CW'(resp);
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + XLEN'(4);
      if (resp && discard != '0)
        discard <= discard - CW'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable imem model.
module tb_if_fetch_unit;

  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  if_fetch_unit #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (64'h100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bd0;
  endfunction

  // In-order memory: accepted at a posedge, answered lat cycles later
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    cyc    = 0;
  int    lat    = 1;
  bit    mem_en = 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (imem_resp_valid && mq.size() > 0)
      void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready)
      mq.push_back('{imem_req_addr, cyc + lat - 1});
  end

  always @(negedge clk) begin
    if (mem_en && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for the next valid output and check it
  task automatic wait_out(input string nm, input logic [63:0] pc);
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      chk({nm, "_pc"}, out_pc, pc);
      chk({nm, "_instr"}, {32'h0, out_instr}, {32'h0, word_of(pc)});
    end
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        ov;
    logic [63:0] pc;
    logic [2:0]  occ;
    logic        rv;
    logic [63:0] addr;
  } vec_t;

  vec_t tv[16];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1'b0, 1'b0, 64'h000, 3'd0, 1'b1, 64'h100};
    tv[1]  = '{1'b0, 1'b0, 64'h000, 3'd0, 1'b1, 64'h104};
    tv[2]  = '{1'b0, 1'b1, 64'h100, 3'd1, 1'b1, 64'h108};
    tv[3]  = '{1'b0, 1'b1, 64'h104, 3'd1, 1'b1, 64'h10c};
    tv[4]  = '{1'b0, 1'b1, 64'h108, 3'd1, 1'b1, 64'h110};
    tv[5]  = '{1'b1, 1'b1, 64'h10c, 3'd1, 1'b1, 64'h114};
    tv[6]  = '{1'b1, 1'b1, 64'h10c, 3'd2, 1'b1, 64'h118};
    tv[7]  = '{1'b1, 1'b1, 64'h10c, 3'd3, 1'b0, 64'h11c};
    tv[8]  = '{1'b1, 1'b1, 64'h10c, 3'd4, 1'b0, 64'h11c};
    tv[9]  = '{1'b1, 1'b1, 64'h10c, 3'd4, 1'b0, 64'h11c};
    tv[10] = '{1'b0, 1'b1, 64'h10c, 3'd4, 1'b0, 64'h11c};
    tv[11] = '{1'b0, 1'b1, 64'h110, 3'd3, 1'b1, 64'h11c};
    tv[12] = '{1'b0, 1'b1, 64'h114, 3'd2, 1'b1, 64'h120};
    tv[13] = '{1'b0, 1'b1, 64'h118, 3'd2, 1'b1, 64'h124};
    tv[14] = '{1'b0, 1'b1, 64'h11c, 3'd2, 1'b1, 64'h128};
    tv[15] = '{1'b0, 1'b1, 64'h120, 3'd2, 1'b1, 64'h12c};

    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_out_instr", {32'h0, out_instr}, {32'h0, NOP_INSTR});
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_occ", {61'h0, occupancy}, 64'd0);

    // Streaming from reset, then a 5-cycle stall
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0)
        rst = 1'b0;
      stall = tv[i].stall;
      #1;
      chk($sformatf("v%0d_ov", i), {63'h0, out_valid},
          {63'h0, tv[i].ov});
      chk($sformatf("v%0d_pc", i), out_pc, tv[i].pc);
      chk($sformatf("v%0d_instr", i), {32'h0, out_instr},
          {32'h0, tv[i].ov ? word_of(tv[i].pc) : NOP_INSTR});
      chk($sformatf("v%0d_occ", i), {61'h0, occupancy},
          {61'h0, tv[i].occ});
      chk($sformatf("v%0d_rv", i), {63'h0, imem_req_valid},
          {63'h0, tv[i].rv});
      chk($sformatf("v%0d_addr", i), imem_req_addr, tv[i].addr);
    end

    // Redirect with three requests in flight, 3-cycle memory
    @(negedge clk);
    rst = 1'b1;
    lat = 3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    #1;
    chk("redir_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("redir_out_valid", {63'h0, out_valid}, 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("redir_addr", imem_req_addr, 64'h200);
    chk("redir_rv", {63'h0, imem_req_valid}, 64'd1);
    wait_out("redir_first", 64'h200);
    wait_out("redir_second", 64'h204);

    // Misaligned target has its low bits cleared
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("misal_addr", imem_req_addr, 64'h200);
    wait_out("misal_first", 64'h200);
    wait_out("misal_second", 64'h204);

    // Redirect while stalled with a full queue
    @(negedge clk);
    stall = 1'b1;
    for (int n = 0; n < 20 && occupancy != 3'd4; n++) begin
      @(negedge clk);
      #1;
    end
    chk("full_occ", {61'h0, occupancy}, 64'd4);
    chk("full_rv", {63'h0, imem_req_valid}, 64'd0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    #1;
    chk("rs_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rs_out_instr", {32'h0, out_instr}, {32'h0, NOP_INSTR});
    chk("rs_rv", {63'h0, imem_req_valid}, 64'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    #1;
    chk("rs_occ", {61'h0, occupancy}, 64'd0);
    chk("rs_addr", imem_req_addr, 64'h300);
    wait_out("rs_first", 64'h300);
    wait_out("rs_second", 64'h304);

    // Reset with two requests outstanding, strays after release
    @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("drain_occ", {61'h0, occupancy}, 64'd0);
    @(negedge clk);
    imem_req_ready = 1'b1;
    mem_en         = 1'b0;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    rst            = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mem_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stray%0d_ov", n), {63'h0, out_valid}, 64'd0);
      chk($sformatf("stray%0d_occ", n), {61'h0, occupancy}, 64'd0);
      chk($sformatf("stray%0d_addr", n), imem_req_addr, 64'h100);
    end
    chk("stray_consumed", 64'(mq.size()), 64'd0);
    @(negedge clk);
    imem_req_ready = 1'b1;
    #1;
    wait_out("post_rst_first", 64'h100);
    wait_out("post_rst_second", 64'h104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
